// File: rtl/fibonacci_engine_if.sv
// Request/response bundle for fibonacci_engine: the request goes in on start/n_in/lucas/abort,
// and the result comes back on busy/done/result/overflow.
interface fibonacci_engine_if #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 7
);
  logic               start;
  logic [N_WIDTH-1:0] n_in;
  logic               lucas;
  logic               abort;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               overflow;

  modport master (
    output start, n_in, lucas, abort,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, n_in, lucas, abort,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/fibonacci_engine.sv
// Iterative Fibonacci/Lucas term calculator. It computes one recurrence step per clock.
// Each term carries a sticky wrap flag so that overflow describes term n itself.
module fibonacci_engine #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  fibonacci_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [N_WIDTH-1:0] cnt_q;
  logic               ovf_a_q;
  logic               ovf_b_q;
  logic [WIDTH-1:0]   result_q;
  logic               overflow_q;
  logic [WIDTH:0]     sum;

  // The extra top bit of the sum is the carry out of the WIDTH-bit addition.
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Abort takes priority over completion, so a cancelled request leaves result untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      ovf_a_q    <= 1'b0;
      ovf_b_q    <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.lucas ? WIDTH'(2) : '0;
            b_q     <= WIDTH'(1);
            cnt_q   <= bus.n_in;
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.abort) begin
            if (cnt_q == '0) begin
              result_q   <= a_q;
              overflow_q <= ovf_a_q;
            end else begin
              a_q     <= b_q;
              b_q     <= sum[WIDTH-1:0];
              ovf_a_q <= ovf_b_q;
              ovf_b_q <= ovf_a_q | ovf_b_q | sum[WIDTH];
              cnt_q   <= cnt_q - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fibonacci_engine.sv
// Self-checking bench for fibonacci_engine at WIDTH=16. It runs fixed vectors, handshake
// corner sequences, and random requests scored against an arithmetic sequence model.
module tb_fibonacci_engine;
  localparam int WIDTH   = 16;
  localparam int N_WIDTH = 7;

  typedef struct {
    int          n;
    bit          lucas;
    int unsigned exp_result;
    bit          exp_ovf;
  } vector_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  fibonacci_engine_if #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) bus ();

  fibonacci_engine #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Exact-value model: true terms saturate well above 2^WIDTH, and the residues are kept mod 2^WIDTH.
  function automatic void ref_term(input int n, input bit luc, output longint res, output bit ovf);
    longint cap;
    longint mod;
    longint at;
    longint bt;
    longint am;
    longint bm;
    longint t;
    cap = longint'(1) << (WIDTH + 2);
    mod = longint'(1) << WIDTH;
    at  = luc ? 2 : 0;
    bt  = 1;
    am  = at;
    bm  = 1;
    for (int i = 0; i < n; i++) begin
      t  = at + bt;
      at = bt;
      bt = (t > cap) ? cap : t;
      t  = (am + bm) % mod;
      am = bm;
      bm = t;
    end
    res = am;
    ovf = (at >= mod);
  endfunction

  task automatic apply_stimulus(input int n, input bit luc, input int poke_k, input int abort_k,
                                output int done_at, output int done_cnt, output int busy_cnt);
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_in  = N_WIDTH'(n);
    bus.lucas = luc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.n_in  = '0;
    bus.lucas = 1'b0;
    for (int k = 0; k < n + 20; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (!bus.busy) break;
      bus.start = (k == poke_k);
      bus.n_in  = (k == poke_k) ? N_WIDTH'(3) : '0;
      bus.lucas = (k == poke_k);
      bus.abort = (k == abort_k);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.n_in  = '0;
    bus.lucas = 1'b0;
    bus.abort = 1'b0;
  endtask

  vector_t vectors[8];
  int      done_at;
  int      done_cnt;
  int      busy_cnt;
  int      rn;
  bit      rl;
  longint  exp_res;
  bit      exp_ovf;
  longint  prior;

  initial begin
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    bus.n_in  = '0;
    bus.lucas = 1'b0;
    bus.abort = 1'b0;
    reset_n   = 1'b0;

    vectors[0] = '{n: 10, lucas: 1'b0, exp_result: 55,    exp_ovf: 1'b0};
    vectors[1] = '{n: 5,  lucas: 1'b1, exp_result: 11,    exp_ovf: 1'b0};
    vectors[2] = '{n: 0,  lucas: 1'b1, exp_result: 2,     exp_ovf: 1'b0};
    vectors[3] = '{n: 0,  lucas: 1'b0, exp_result: 0,     exp_ovf: 1'b0};
    vectors[4] = '{n: 1,  lucas: 1'b0, exp_result: 1,     exp_ovf: 1'b0};
    vectors[5] = '{n: 24, lucas: 1'b0, exp_result: 46368, exp_ovf: 1'b0};
    vectors[6] = '{n: 25, lucas: 1'b0, exp_result: 9489,  exp_ovf: 1'b1};
    vectors[7] = '{n: 23, lucas: 1'b1, exp_result: 64079, exp_ovf: 1'b0};

    repeat (3) @(negedge clk);
    check_output("reset_busy", bus.busy, 0);
    check_output("reset_done", bus.done, 0);
    check_output("reset_result", bus.result, 0);
    check_output("reset_overflow", bus.overflow, 0);
    reset_n = 1'b1;

    foreach (vectors[i]) begin
      apply_stimulus(vectors[i].n, vectors[i].lucas, -1, -1, done_at, done_cnt, busy_cnt);
      check_output($sformatf("vec%0d_result", i), bus.result, vectors[i].exp_result);
      check_output($sformatf("vec%0d_overflow", i), bus.overflow, vectors[i].exp_ovf);
      check_output($sformatf("vec%0d_done_at", i), done_at, vectors[i].n + 1);
      check_output($sformatf("vec%0d_done_cnt", i), done_cnt, 1);
      check_output($sformatf("vec%0d_busy_cnt", i), busy_cnt, vectors[i].n + 2);
    end

    // A start pulse during RUN must neither restart nor queue a second request.
    apply_stimulus(10, 1'b0, 3, -1, done_at, done_cnt, busy_cnt);
    check_output("poke_result", bus.result, 55);
    check_output("poke_done_at", done_at, 11);
    check_output("poke_done_cnt", done_cnt, 1);
    repeat (20) begin
      @(negedge clk);
      if (bus.busy || bus.done) done_cnt++;
    end
    check_output("poke_no_second_request", done_cnt, 1);

    prior = bus.result;
    apply_stimulus(20, 1'b0, -1, 5, done_at, done_cnt, busy_cnt);
    check_output("abort_done_cnt", done_cnt, 0);
    check_output("abort_busy_cnt", busy_cnt, 6);
    check_output("abort_result_kept", bus.result, prior);
    apply_stimulus(7, 1'b0, -1, -1, done_at, done_cnt, busy_cnt);
    check_output("after_abort_result", bus.result, 13);
    check_output("after_abort_done_cnt", done_cnt, 1);

    // Overflowing request first, so that reset visibly clears a nonzero result and overflow.
    apply_stimulus(30, 1'b0, -1, -1, done_at, done_cnt, busy_cnt);
    check_output("pre_reset_overflow", bus.overflow, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.n_in  = N_WIDTH'(20);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_reset_busy", bus.busy, 0);
    check_output("async_reset_done", bus.done, 0);
    check_output("async_reset_result", bus.result, 0);
    check_output("async_reset_overflow", bus.overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(12, 1'b0, -1, -1, done_at, done_cnt, busy_cnt);
    check_output("post_reset_result", bus.result, 144);
    check_output("post_reset_done_at", done_at, 13);

    for (int r = 0; r < 30; r++) begin
      rn = (r % 5 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 40));
      rl = 1'($urandom_range(0, 1));
      ref_term(rn, rl, exp_res, exp_ovf);
      apply_stimulus(rn, rl, -1, -1, done_at, done_cnt, busy_cnt);
      check_output($sformatf("rand%0d_n%0d_l%0d_result", r, rn, rl), bus.result, exp_res);
      check_output($sformatf("rand%0d_n%0d_l%0d_overflow", r, rn, rl), bus.overflow, exp_ovf);
      check_output($sformatf("rand%0d_done_at", r), done_at, rn + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fibonacci_engine.md
# fibonacci_engine

Parametrised, handshaked iterative calculator for Fibonacci and Lucas sequence terms. A single request (term index plus sequence select) is accepted while idle. The block computes one recurrence step per clock and returns the term with a one-cycle done pulse and a wrap-around flag. It is a drop-in compute block for the sequence-generator datapath, replacing fixed-width, free-running calculators with a configurable, explicitly controlled engine.

## Interface
Parameters:
- WIDTH, 32, bit width of the internal terms and of result (minimum 2)
- N_WIDTH, 7, bit width of the requested term index n

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request strobe; sampled only in IDLE
- n_in  input  N_WIDTH  requested term index n (unsigned)
- lucas  input  1  sequence select, sampled with start: 0 = Fibonacci, 1 = Lucas
- abort  input  1  synchronous cancel of a computation in progress
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  term n modulo 2^WIDTH; held until the next accepted start
- overflow  output  1  high when result wrapped; held with result

## Operation
- Seeds:
  - Fibonacci: a = 0, b = 1.
  - Lucas: a = 2, b = 1.
- Recurrence step: a <= b; b <= a + b, truncated to WIDTH bits; cnt <= cnt - 1.
- Overflow tracking:
  - Each term register carries a wrap flag, ovf_a and ovf_b, both cleared at load.
  - On each step: ovf_a <= ovf_b; ovf_b <= ovf_a | ovf_b | carry_out(a + b).
  - overflow therefore reports whether term n itself exceeded 2^WIDTH - 1. A wrap in the look-ahead term b alone does not set it.
- States:
  - IDLE: busy = 0. If start = 1, load the seeds, set cnt = n_in, latch the sequence select, go to RUN.
  - RUN:
    - If abort = 1, go to IDLE. No done pulse; result and overflow keep their previous values.
    - Else if cnt = 0, set result <= a and overflow <= ovf_a, go to DONE.
    - Otherwise perform one recurrence step and stay in RUN.
  - DONE: done = 1 for exactly one cycle, then go to IDLE unconditionally.
- Input handling:
  - start, n_in and lucas are ignored outside IDLE. No request is queued.
  - abort is ignored in IDLE and DONE.
  - A start in the first IDLE cycle after DONE is accepted; back-to-back throughput is n + 3 cycles per request.
- Width rules:
  - cnt is N_WIDTH bits.
  - The carry is bit WIDTH of a (WIDTH+1)-bit sum.
  - result is the low WIDTH bits, never saturated.

## Timing
- Reset (reset_n = 0, asynchronous):
  - state = IDLE, busy = 0, done = 0, result = 0, overflow = 0, and internal a/b/cnt/flags = 0.
  - Takes effect immediately, including mid-computation. No done pulse follows.
- Release: the first edge with reset_n = 1 may accept a start.
- Latency, with start sampled at edge E:
  - busy rises after E.
  - result and overflow update at edge E + n + 1.
  - done is high between edges E + n + 1 and E + n + 2.
  - busy falls after E + n + 2.
- n = 0: done is high between edges E + 1 and E + 2, with result equal to the seed a.
- result and overflow change only at the RUN-to-DONE transition and on reset.
- abort and cnt = 0 in the same RUN cycle: abort wins.

## Test plan
- WIDTH=16, Fibonacci, n=10 -> result=55, overflow=0; done high exactly 11 cycles after the start edge; busy high for 12 cycles.
- Lucas, n=5 -> result=11. Lucas, n=0 -> result=2. Fibonacci, n=0 -> result=0 with done 1 cycle after the start edge. Fibonacci, n=1 -> result=1.
- WIDTH=16, Fibonacci, n=24 -> result=46368, overflow=0, even though the look-ahead term 75025 wrapped internally. n=25 -> result=9489, overflow=1.
- Start pulsed during RUN with n_in=3 and lucas=1 -> ignored; the original request completes unchanged, and only one done pulse appears.
- Abort asserted mid-RUN (n=20) -> back in IDLE the next cycle; no done pulse; result keeps its prior value. A new start with n=7 then gives 13.
- reset_n driven low asynchronously mid-RUN (between edges) -> busy, done, result and overflow go to 0 immediately. After release, a Fibonacci request with n=12 gives 144.
